axi_lite_cmd_arbiter: RTL and testbench

- Shares the single user-command port of the AXI-Lite master between two requesters, e.g. the switch-driven BFM and a second traffic source.
- Requests are granted one transaction at a time in round-robin order.
- Each granted request is issued as a one-cycle C_VALID or C_VALID_R pulse. The block then waits for the master's completion and returns an ACK (plus read data or a timeout error) to the winning requester.

---
 rtl/axi_lite_arb_pkg.sv | 24 ++
 rtl/axi_lite_cmd_arbiter_rr_arb2.sv | 27 ++
 rtl/axi_lite_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_lite_cmd_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite command arbiter.
package axi_lite_arb_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_W = 3'd1,
    ST_ISSUE_R = 3'd2,
    ST_WAIT_W  = 3'd3,
    ST_WAIT_R  = 3'd4,
    ST_RESP    = 3'd5
  } arb_state_e;

  // Requester identifiers
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Default completion timeout in WAIT cycles
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Timeout counter width (covers TIMEOUT up to 65535)
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/axi_lite_cmd_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick.
//   pending     : request pending per requester
//   last        : requester granted most recently
//   winner_c    : chosen requester (valid when any_valid_c)
//   any_valid_c : at least one requester pending
module rr_arb2
  import axi_lite_arb_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last,
  output logic       winner_c,
  output logic       any_valid_c
);

  // On a tie the requester that did not win last time goes first
  always_comb begin
    winner_c    = REQ0;
    any_valid_c = |pending;
    case (pending)
      2'b01:   winner_c = REQ0;
      2'b10:   winner_c = REQ1;
      2'b11:   winner_c = ~last;
      default: winner_c = REQ0;
    endcase
  end

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// Shares the AXI-Lite master user-command port between two requesters.
// One transaction at a time, round-robin; each grant issues a single-cycle
// C_VALID / C_VALID_R pulse, waits for W_DONE / R_DONE (or a timeout), then
// returns a one-cycle ACK to the winner.
//   clk, reset_n                 : clock, async active-low reset
//   REQ_WR/REQ_RD/REQ_ADDR/
//   REQ_WDATA/REQ_STRB           : requester side (level requests)
//   ACK/ERR/RDATA                : completion back to requesters
//   BUSY/GRANT_ID                : status
//   C_VALID/C_ADRR/C_DATA/C_STRB : write command to master
//   C_VALID_R/C_ADRR_R           : read command to master
//   W_DONE/R_DONE/R_DATA         : completion from master
module axi_lite_cmd_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            REQ_WR,
  input  logic [1:0]            REQ_RD,
  input  logic [2*ADDR_W-1:0]   REQ_ADDR,
  input  logic [2*DATA_W-1:0]   REQ_WDATA,
  input  logic [7:0]            REQ_STRB,
  output logic [1:0]            ACK,
  output logic                  ERR,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  BUSY,
  output logic                  GRANT_ID,
  output logic                  C_VALID,
  output logic [ADDR_W-1:0]     C_ADRR,
  output logic [DATA_W-1:0]     C_DATA,
  output logic [3:0]            C_STRB,
  output logic                  C_VALID_R,
  output logic [ADDR_W-1:0]     C_ADRR_R,
  input  logic                  W_DONE,
  input  logic                  R_DONE,
  input  logic [DATA_W-1:0]     R_DATA
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state;
  logic             last_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]        pending;
  logic              winner;
  logic              any_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [3:0]        win_strb;
  logic              win_wr;
  logic              timed_out;

  assign pending = REQ_WR | REQ_RD;

  rr_arb2 u_rr_arb2 (
    .pending     (pending),
    .last        (last_q),
    .winner_c    (winner),
    .any_valid_c (any_valid)
  );

  // Winner's payload slice
  assign win_addr  = winner ? REQ_ADDR[2*ADDR_W-1:ADDR_W]   : REQ_ADDR[ADDR_W-1:0];
  assign win_data  = winner ? REQ_WDATA[2*DATA_W-1:DATA_W]  : REQ_WDATA[DATA_W-1:0];
  assign win_strb  = winner ? REQ_STRB[7:4]                 : REQ_STRB[3:0];
  assign win_wr    = winner ? REQ_WR[1]                     : REQ_WR[0];
  assign timed_out = (cnt == CNT_LAST);

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last_q    <= REQ1;
      cnt       <= '0;
      ACK       <= 2'b00;
      ERR       <= 1'b0;
      RDATA     <= '0;
      BUSY      <= 1'b0;
      GRANT_ID  <= 1'b0;
      C_VALID   <= 1'b0;
      C_ADRR    <= '0;
      C_DATA    <= '0;
      C_STRB    <= 4'h0;
      C_VALID_R <= 1'b0;
      C_ADRR_R  <= '0;
    end else begin
      // Pulse outputs default low
      C_VALID   <= 1'b0;
      C_VALID_R <= 1'b0;
      ACK       <= 2'b00;
      ERR       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            GRANT_ID <= winner;
            last_q   <= winner;
            C_ADRR   <= win_addr;
            C_ADRR_R <= win_addr;
            C_DATA   <= win_data;
            C_STRB   <= win_strb;
            BUSY     <= 1'b1;
            // Write wins over read within one requester
            if (win_wr) begin
              state   <= ST_ISSUE_W;
              C_VALID <= 1'b1;
            end else begin
              state     <= ST_ISSUE_R;
              C_VALID_R <= 1'b1;
            end
          end
        end
        ST_ISSUE_W: state <= ST_WAIT_W;
        ST_ISSUE_R: state <= ST_WAIT_R;
        ST_WAIT_W: begin
          cnt <= cnt + CNT_W'(1);
          // Done takes precedence over a same-cycle timeout
          if (W_DONE || timed_out) begin
            state <= ST_RESP;
            ACK   <= 2'b01 << GRANT_ID;
            ERR   <= ~W_DONE;
          end
        end
        ST_WAIT_R: begin
          cnt <= cnt + CNT_W'(1);
          if (R_DONE) begin
            state <= ST_RESP;
            ACK   <= 2'b01 << GRANT_ID;
            RDATA <= R_DATA;
          end else if (timed_out) begin
            state <= ST_RESP;
            ACK   <= 2'b01 << GRANT_ID;
            ERR   <= 1'b1;
          end
        end
        ST_RESP: begin
          cnt   <= '0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed self-checking bench for axi_lite_cmd_arbiter (TIMEOUT = 8).
module tb_axi_lite_cmd_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic                clk;
  logic                reset_n;
  logic [1:0]          REQ_WR;
  logic [1:0]          REQ_RD;
  logic [2*ADDR_W-1:0] REQ_ADDR;
  logic [2*DATA_W-1:0] REQ_WDATA;
  logic [7:0]          REQ_STRB;
  logic [1:0]          ACK;
  logic                ERR;
  logic [DATA_W-1:0]   RDATA;
  logic                BUSY;
  logic                GRANT_ID;
  logic                C_VALID;
  logic [ADDR_W-1:0]   C_ADRR;
  logic [DATA_W-1:0]   C_DATA;
  logic [3:0]          C_STRB;
  logic                C_VALID_R;
  logic [ADDR_W-1:0]   C_ADRR_R;
  logic                W_DONE;
  logic                R_DONE;
  logic [DATA_W-1:0]   R_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_cmd_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .REQ_WR    (REQ_WR),
    .REQ_RD    (REQ_RD),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_STRB  (REQ_STRB),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .BUSY      (BUSY),
    .GRANT_ID  (GRANT_ID),
    .C_VALID   (C_VALID),
    .C_ADRR    (C_ADRR),
    .C_DATA    (C_DATA),
    .C_STRB    (C_STRB),
    .C_VALID_R (C_VALID_R),
    .C_ADRR_R  (C_ADRR_R),
    .W_DONE    (W_DONE),
    .R_DONE    (R_DONE),
    .R_DATA    (R_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [169:0] all_outs();
    return {ACK, ERR, RDATA, BUSY, GRANT_ID, C_VALID, C_ADRR, C_DATA,
            C_STRB, C_VALID_R, C_ADRR_R};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    REQ_WR    = 2'b00;
    REQ_RD    = 2'b00;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    REQ_STRB  = 8'h00;
    W_DONE    = 1'b0;
    R_DONE    = 1'b0;
    R_DATA    = '0;
    #12;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_write();
    REQ_ADDR  = '0;
    REQ_WDATA = {32'h0, 32'h0000_1234};
    REQ_STRB  = 8'h0F;
    REQ_WR    = 2'b01;
    tick();  // ISSUE_W
    n_checks++;
    if ({C_VALID, C_VALID_R, GRANT_ID, BUSY} !== 4'b1001) begin
      n_fail++;
      $display("FAIL write_issue_flags: got %b expected 1001", {C_VALID, C_VALID_R, GRANT_ID, BUSY});
    end
    n_checks++;
    if ({C_ADRR, C_DATA, C_STRB} !== {32'h0, 32'h0000_1234, 4'hF}) begin
      n_fail++;
      $display("FAIL write_payload: got %h %h %h expected 0 00001234 f", C_ADRR, C_DATA, C_STRB);
    end
    tick();  // WAIT_W cnt 0
    n_checks++;
    if (C_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL write_pulse_width: got %b expected 0", C_VALID);
    end
    tick();
    tick();
    W_DONE = 1'b1;  // three cycles after the pulse
    tick();  // RESP
    W_DONE = 1'b0;
    n_checks++;
    if ({ACK, ERR} !== 3'b010) begin
      n_fail++;
      $display("FAIL write_ack: got %b expected 010", {ACK, ERR});
    end
    n_checks++;
    if (C_DATA !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL write_data_hold: got %h expected 00001234", C_DATA);
    end
    REQ_WR = 2'b00;
    tick();  // IDLE
    n_checks++;
    if ({ACK, BUSY} !== 3'b000) begin
      n_fail++;
      $display("FAIL write_done_idle: got %b expected 000", {ACK, BUSY});
    end
  endtask

  task automatic test_read();
    REQ_ADDR = {32'h0000_0004, 32'h0};
    REQ_RD   = 2'b10;
    tick();  // ISSUE_R
    n_checks++;
    if ({C_VALID_R, C_VALID, GRANT_ID} !== 3'b101) begin
      n_fail++;
      $display("FAIL read_issue_flags: got %b expected 101", {C_VALID_R, C_VALID, GRANT_ID});
    end
    n_checks++;
    if (C_ADRR_R !== 32'h4) begin
      n_fail++;
      $display("FAIL read_addr: got %h expected 00000004", C_ADRR_R);
    end
    tick();  // WAIT_R
    R_DONE = 1'b1;
    R_DATA = 32'h0000_5A5A;
    tick();  // RESP
    R_DONE = 1'b0;
    R_DATA = 32'h0;
    n_checks++;
    if ({ACK, ERR} !== 3'b100) begin
      n_fail++;
      $display("FAIL read_ack: got %b expected 100", {ACK, ERR});
    end
    n_checks++;
    if (RDATA !== 32'h0000_5A5A) begin
      n_fail++;
      $display("FAIL read_rdata: got %h expected 00005a5a", RDATA);
    end
    REQ_RD = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] exp_addr;
    logic [1:0]        exp_ack;
    logic              exp_gid;
    REQ_ADDR  = {32'h0000_0020, 32'h0000_0010};
    REQ_WDATA = {32'h0000_00B1, 32'h0000_00A0};
    REQ_STRB  = 8'h3C;
    REQ_WR    = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_gid  = (k == 1);
      exp_addr = exp_gid ? 32'h20 : 32'h10;
      exp_ack  = exp_gid ? 2'b10 : 2'b01;
      tick();  // ISSUE_W
      n_checks++;
      if ({C_VALID, GRANT_ID} !== {1'b1, exp_gid}) begin
        n_fail++;
        $display("FAIL contention_grant_%0d: got %b expected %b", k, {C_VALID, GRANT_ID}, {1'b1, exp_gid});
      end
      n_checks++;
      if (C_ADRR !== exp_addr) begin
        n_fail++;
        $display("FAIL contention_addr_%0d: got %h expected %h", k, C_ADRR, exp_addr);
      end
      tick();  // WAIT_W
      W_DONE = 1'b1;
      n_checks++;
      if (C_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_no_overlap_%0d: got %b expected 0", k, C_VALID);
      end
      tick();  // RESP
      W_DONE = 1'b0;
      n_checks++;
      if ({ACK, C_VALID} !== {exp_ack, 1'b0}) begin
        n_fail++;
        $display("FAIL contention_ack_%0d: got %b expected %b", k, {ACK, C_VALID}, {exp_ack, 1'b0});
      end
      if (k == 2) REQ_WR = 2'b00;
      tick();  // IDLE
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_end_idle: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_timeout();
    int early_acks;
    early_acks = 0;
    REQ_ADDR = {32'h0, 32'h0000_0008};
    R_DATA   = 32'hDEAD_BEEF;  // must not be captured without R_DONE
    REQ_RD   = 2'b01;
    tick();  // ISSUE_R
    n_checks++;
    if ({C_VALID_R, GRANT_ID} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_issue: got %b expected 10", {C_VALID_R, GRANT_ID});
    end
    for (int i = 0; i < 8; i++) begin
      tick();  // WAIT_R cycles 0..7
      if (ACK !== 2'b00) early_acks++;
    end
    n_checks++;
    if (early_acks != 0) begin
      n_fail++;
      $display("FAIL timeout_early_ack: got %0d acks expected 0", early_acks);
    end
    tick();  // RESP
    n_checks++;
    if ({ACK, ERR} !== 3'b011) begin
      n_fail++;
      $display("FAIL timeout_ack_err: got %b expected 011", {ACK, ERR});
    end
    n_checks++;
    if (RDATA !== 32'h0000_5A5A) begin
      n_fail++;
      $display("FAIL timeout_rdata_hold: got %h expected 00005a5a", RDATA);
    end
    REQ_RD = 2'b00;
    R_DATA = 32'h0;
    tick();
  endtask

  task automatic test_stray_events();
    REQ_ADDR  = {32'h0000_0030, 32'h0};
    REQ_WDATA = {32'h0000_0077, 32'h0};
    REQ_WR    = 2'b10;
    tick();  // ISSUE_W
    W_DONE = 1'b1;  // done during ISSUE must be ignored
    tick();  // WAIT_W cnt 0
    W_DONE = 1'b0;
    n_checks++;
    if ({ACK, BUSY} !== 3'b001) begin
      n_fail++;
      $display("FAIL stray_issue_done: got %b expected 001", {ACK, BUSY});
    end
    R_DONE = 1'b1;  // wrong-type done in WAIT_W
    R_DATA = 32'h1111_1111;
    tick();  // WAIT_W cnt 1
    R_DONE = 1'b0;
    R_DATA = 32'h0;
    n_checks++;
    if ({ACK, BUSY} !== 3'b001) begin
      n_fail++;
      $display("FAIL stray_read_done: got %b expected 001", {ACK, BUSY});
    end
    for (int i = 0; i < 6; i++) tick();  // cnt 7: last timeout cycle
    n_checks++;
    if (ACK !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_premature_ack: got %b expected 00", ACK);
    end
    W_DONE = 1'b1;
    tick();  // RESP
    W_DONE = 1'b0;
    n_checks++;
    if ({ACK, ERR, GRANT_ID} !== 4'b1001) begin
      n_fail++;
      $display("FAIL stray_done_beats_timeout: got %b expected 1001", {ACK, ERR, GRANT_ID});
    end
    n_checks++;
    if (RDATA !== 32'h0000_5A5A) begin
      n_fail++;
      $display("FAIL stray_rdata_hold: got %h expected 00005a5a", RDATA);
    end
    REQ_WR = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int stray_acks;
    stray_acks = 0;
    REQ_ADDR = {32'h0000_0044, 32'h0000_0040};
    REQ_WR   = 2'b01;  // makes last = 0 before the reset
    tick();  // ISSUE_W
    tick();  // WAIT_W
    tick();  // WAIT_W
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0", all_outs());
    end
    W_DONE = 1'b1;
    tick();
    if (ACK !== 2'b00) stray_acks++;
    REQ_WR  = 2'b00;
    W_DONE  = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ACK !== 2'b00) stray_acks++;
    end
    n_checks++;
    if (stray_acks != 0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_ack: got acks=%0d busy=%b expected 0 0", stray_acks, BUSY);
    end
    REQ_WR = 2'b11;  // tie after reset
    tick();
    n_checks++;
    if ({C_VALID, GRANT_ID, C_ADRR} !== {1'b1, 1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL midreset_tie_winner: got %b %b %h expected 1 0 00000040", C_VALID, GRANT_ID, C_ADRR);
    end
    tick();  // WAIT_W
    W_DONE = 1'b1;
    tick();  // RESP
    W_DONE = 1'b0;
    REQ_WR = 2'b00;
    n_checks++;
    if ({ACK, ERR} !== 3'b010) begin
      n_fail++;
      $display("FAIL midreset_final_ack: got %b expected 010", {ACK, ERR});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_stray_events();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
